alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_if.sv | 28 ++
 rtl/alu_exec_unit.sv | 176 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response handshake bundle for alu_exec_unit.
//   req_valid/req_ready : request handshake (operands + opcode)
//   req_a, req_b        : 8-bit operands
//   req_sel             : 4-bit opcode
//   rsp_valid/rsp_ready : response handshake (FIFO head)
//   rsp_out, rsp_carry  : 8-bit result and carry/flag bit
// Modports: slave = the execution unit, master = the requester/consumer.
interface alu_exec_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_sel;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_out;
  logic       rsp_carry;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_carry
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_carry
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 8-bit ALU with a 2-entry in-order result FIFO.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_exec_if.slave request/response handshake
//   busy : high while the divider FSM is not idle
// Optional feature: define ALU_EXEC_ITER_DIV_EN to get an iterative
// 8-cycle restoring divider for opcode 3 (IDLE/DIV/DONE FSM). Without
// it, opcode 3 is a single-cycle op returning 0/0 and busy is tied low.
module alu_exec_unit #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  alu_exec_if.slave   bus,
  output logic        busy
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  // FIFO entries hold {carry, out}; slot0 is the head.
  logic [1:0]  count;
  logic [8:0]  slot0;
  logic [8:0]  slot1;
  logic        accept;
  logic        pop;
  logic        push;
  logic [8:0]  push_data;

  logic [8:0]  sum9;
  logic [15:0] prod;
  logic [8:0]  alu_res;

  always_comb begin
    sum9    = {1'b0, bus.req_a} + {1'b0, bus.req_b};
    prod    = 16'(bus.req_a) * 16'(bus.req_b);
    alu_res = '0;
    case (bus.req_sel)
      4'd0:  alu_res = sum9;
      4'd1:  alu_res = {(bus.req_a < bus.req_b), bus.req_a - bus.req_b};
      4'd2:  alu_res = {(|prod[15:8]), prod[7:0]};
      4'd4:  alu_res = {bus.req_a[7], bus.req_a[6:0], 1'b0};
      4'd5:  alu_res = {bus.req_a[0], 1'b0, bus.req_a[7:1]};
      4'd6:  alu_res = {1'b0, bus.req_a[6:0], bus.req_a[7]};
      4'd7:  alu_res = {1'b0, bus.req_a[0], bus.req_a[7:1]};
      4'd8:  alu_res = {1'b0, bus.req_a & bus.req_b};
      4'd9:  alu_res = {1'b0, bus.req_a | bus.req_b};
      4'd10: alu_res = {1'b0, bus.req_a ^ bus.req_b};
      4'd11: alu_res = {1'b0, ~(bus.req_a | bus.req_b)};
      4'd12: alu_res = {1'b0, ~(bus.req_a & bus.req_b)};
      4'd13: alu_res = {1'b0, ~(bus.req_a ^ bus.req_b)};
      4'd14: alu_res = {8'd0, (bus.req_a > bus.req_b)};
      4'd15: alu_res = {8'd0, (bus.req_a == bus.req_b)};
      default: alu_res = '0;
    endcase
  end

  assign pop           = (count != 2'd0) && bus.rsp_ready;
  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_out   = slot0[7:0];
  assign bus.rsp_carry = slot0[8];

`ifdef ALU_EXEC_ITER_DIV_EN
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t     state;
  logic [7:0] div_q;    // dividend shifting out MSB-first, quotient shifting in
  logic [7:0] div_b;
  logic [7:0] div_r;
  logic       div_z;    // divide-by-zero flag forces carry
  logic [2:0] div_cnt;
  logic [8:0] rem_shift;
  logic [7:0] diff;
  logic       ge;
  logic       done_push;

  assign rem_shift = {div_r, div_q[7]};
  assign ge        = rem_shift >= {1'b0, div_b};
  // When ge holds the true difference is below div_b, so 8 bits suffice.
  assign diff      = rem_shift[7:0] - div_b;

  assign bus.req_ready = !rst && (state == IDLE) && (count < FULL);
  assign accept        = bus.req_valid && bus.req_ready;
  assign done_push     = (state == DONE) && ((count < FULL) || pop);
  assign push          = (accept && (bus.req_sel != 4'd3)) || done_push;
  assign push_data     = (state == DONE) ? {div_z | (div_r != '0), div_q} : alu_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      div_q   <= '0;
      div_b   <= '0;
      div_r   <= '0;
      div_z   <= 1'b0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (bus.req_sel == 4'd3)) begin
            busy <= 1'b1;
            if (bus.req_b == 8'd0) begin
              div_q <= '1;
              div_r <= '0;
              div_z <= 1'b1;
              state <= DONE;
            end else begin
              div_q   <= bus.req_a;
              div_b   <= bus.req_b;
              div_r   <= '0;
              div_z   <= 1'b0;
              div_cnt <= '0;
              state   <= DIV;
            end
          end
        end
        DIV: begin
          div_r   <= ge ? diff : rem_shift[7:0];
          div_q   <= {div_q[6:0], ge};
          div_cnt <= div_cnt + 3'd1;
          if (div_cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          if (done_push) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign bus.req_ready = !rst && (count < FULL);
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = accept;
  assign push_data     = alu_res;
  assign busy          = 1'b0;
`endif

  // Shift-register FIFO: a pop moves slot1 into the head; a push lands in
  // the first free slot after the pop is accounted for.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven vectors plus hand-written handshake,
// backpressure, divider and reset sequences for alu_exec_unit.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  alu_exec_if bus ();

  alu_exec_unit #(.FIFO_DEPTH(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] out;
    logic       carry;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] sb[$];
  int         tests = 0;
  int         fails = 0;

  function automatic vec_t mk(logic [7:0] a, logic [7:0] b, logic [3:0] sel,
                              logic [7:0] out, logic carry);
    vec_t v;
    v.a = a; v.b = b; v.sel = sel; v.out = out; v.carry = carry;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: compares each consumed head result against the
  // scoreboard; reset discards everything outstanding.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got %0h expected none", {bus.rsp_carry, bus.rsp_out});
      end else begin
        check("rsp", {23'd0, bus.rsp_carry, bus.rsp_out}, {23'd0, sb.pop_front()});
      end
    end
  end

  // Called just after a rising edge. Returns just after the acceptance edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                      input logic [8:0] exp, input bit chk_lat);
    int unsigned n = 0;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sel   = s;
    bus.req_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        bus.req_valid = 1'b0;
        return;
      end
    end
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (chk_lat) check("lat1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    bus.rsp_ready = 1'b1;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_rsp(output int unsigned n);
    n = 0;
    while (!bus.rsp_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;

    vecs.push_back(mk(8'h0A, 8'h02, 4'd0,  8'h0C, 1'b0));
    vecs.push_back(mk(8'h0A, 8'h02, 4'd1,  8'h08, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd0,  8'h00, 1'b1));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd1,  8'hEC, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd2,  8'h9C, 1'b1));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd4,  8'hEC, 1'b1));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd5,  8'h7B, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd6,  8'hED, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd7,  8'h7B, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd8,  8'h02, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd9,  8'hFE, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd10, 8'hFC, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd11, 8'h01, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd12, 8'hFD, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd13, 8'h03, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd14, 8'h01, 1'b0));
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd15, 8'h00, 1'b0));
    vecs.push_back(mk(8'h0A, 8'hF6, 4'd1,  8'h14, 1'b1));
    vecs.push_back(mk(8'h0A, 8'hF6, 4'd14, 8'h00, 1'b0));
    vecs.push_back(mk(8'h55, 8'h55, 4'd15, 8'h01, 1'b0));
    vecs.push_back(mk(8'h55, 8'h55, 4'd14, 8'h00, 1'b0));
    vecs.push_back(mk(8'h55, 8'h55, 4'd1,  8'h00, 1'b0));
    vecs.push_back(mk(8'h81, 8'h00, 4'd4,  8'h02, 1'b1));
    vecs.push_back(mk(8'h81, 8'h00, 4'd5,  8'h40, 1'b1));
    vecs.push_back(mk(8'h81, 8'h00, 4'd6,  8'h03, 1'b0));
    vecs.push_back(mk(8'h81, 8'h00, 4'd7,  8'hC0, 1'b0));
    vecs.push_back(mk(8'h10, 8'h10, 4'd2,  8'h00, 1'b1));
    vecs.push_back(mk(8'h0F, 8'h11, 4'd2,  8'hFF, 1'b0));
    vecs.push_back(mk(8'hFF, 8'h01, 4'd0,  8'h00, 1'b1));
    vecs.push_back(mk(8'h00, 8'h01, 4'd1,  8'hFF, 1'b1));
`ifndef ALU_EXEC_ITER_DIV_EN
    vecs.push_back(mk(8'hF6, 8'h0A, 4'd3,  8'h00, 1'b0));
`endif

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_out",   32'(bus.rsp_out),   32'd0);
    check("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Table-driven vectors, consumer always ready
    bus.rsp_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sel, {vecs[i].carry, vecs[i].out}, 1'b1);
`ifndef ALU_EXEC_ITER_DIV_EN
      if (vecs[i].sel == 4'd3) check("nodiv_busy", 32'(busy), 32'd0);
`endif
    end
    drain();

    // Backpressure: two fill the FIFO, third waits until the consumer pops
    bus.rsp_ready = 1'b0;
    send(8'h01, 8'h02, 4'd0, 9'h003, 1'b1);
    send(8'h03, 8'h04, 4'd0, 9'h007, 1'b1);
    check("full_req_ready", 32'(bus.req_ready), 32'd0);
    fork
      send(8'h05, 8'h06, 4'd0, 9'h00B, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("hold_rsp_out",   32'(bus.rsp_out),   32'h03);
          check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

`ifdef ALU_EXEC_ITER_DIV_EN
    // Divide 0xF6/0x0A; operands disturbed after acceptance
    send(8'hF6, 8'h0A, 4'd3, 9'h118, 1'b0);
    bus.req_a = 8'h01;
    bus.req_b = 8'h01;
    check("div_busy",      32'(busy),          32'd1);
    check("div_req_ready", 32'(bus.req_ready), 32'd0);
    wait_rsp(n);
    check("div_latency", n, 32'd9);
    drain();
    check("div_idle_busy", 32'(busy), 32'd0);

    // Divide by zero skips iteration
    send(8'h37, 8'h00, 4'd3, 9'h1FF, 1'b0);
    wait_rsp(n);
    check("div0_latency", n, 32'd1);
    drain();

    // Exact divide, remainder zero
    send(8'h64, 8'h05, 4'd3, 9'h014, 1'b0);
    drain();

    // Divide behind a buffered result with the consumer stalled
    bus.rsp_ready = 1'b0;
    send(8'h11, 8'h22, 4'd9, 9'h033, 1'b1);
    send(8'h64, 8'h07, 4'd3, 9'h10E, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("divq_busy",      32'(busy),          32'd0);
    check("divq_req_ready", 32'(bus.req_ready), 32'd0);
    check("divq_head",      32'(bus.rsp_out),   32'h33);
    drain();

    // Reset in the middle of a division
    send(8'hF6, 8'h0A, 4'd3, 9'h118, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("divrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("divrst_busy",      32'(busy),          32'd0);
    rst = 1'b0;
    #1;
    check("divrst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (14) @(posedge clk);
    #1;
    check("divrst_no_stale", 32'(bus.rsp_valid), 32'd0);
`endif

    // Reset with the FIFO occupied
    bus.rsp_ready = 1'b0;
    send(8'h20, 8'h03, 4'd0, 9'h023, 1'b1);
    send(8'h20, 8'h03, 4'd1, 9'h01D, 1'b1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("fiforst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("fiforst_rsp_out",   32'(bus.rsp_out),   32'd0);
    check("fiforst_busy",      32'(busy),          32'd0);
    check("fiforst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("fiforst_req_ready_after", 32'(bus.req_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("fiforst_no_stale", 32'(bus.rsp_valid), 32'd0);

    // Traffic still flows after reset
    send(8'h0A, 8'h02, 4'd0, 9'h00C, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
